// File: rtl/bp_update_queue.sv
// Small FIFO that buffers resolved-branch records until the predictor can absorb them.
// Only conditional branches and mispredicted control flow are kept; overflow is counted.
module bp_update_queue #(
  parameter int DEPTH = 4,
  parameter int VLEN  = 64,
  parameter int TGTW  = 128
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            res_valid_i,
  input  logic [VLEN-1:0] res_pc_i,
  input  logic [TGTW-1:0] res_target_i,
  input  logic            res_taken_i,
  input  logic            res_mispredict_i,
  input  logic [2:0]      res_cf_i,
  output logic            upd_valid_o,
  input  logic            upd_ready_i,
  output logic [VLEN-1:0] upd_pc_o,
  output logic [TGTW-1:0] upd_target_o,
  output logic            upd_taken_o,
  output logic            upd_mispredict_o,
  output logic [2:0]      upd_cf_o,
  output logic            full_o,
  output logic [15:0]     drop_cnt_o,
  output logic [31:0]     mispredict_cnt_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int RW = VLEN + TGTW + 5;

  logic [RW-1:0]  mem_reg [DEPTH];
  logic [AW-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]  count_reg, count_next;
  logic [15:0]    drop_cnt_reg;
  logic [31:0]    misp_cnt_reg;

  logic           eligible, is_full, is_empty, pop, push, drop;
  logic [RW-1:0]  wr_data, head_data;

  assign eligible = res_valid_i && ((res_cf_i == 3'd1) || res_mispredict_i);
  assign is_full  = (count_reg == CW'(DEPTH));
  assign is_empty = (count_reg == '0);
  assign pop      = !is_empty && upd_ready_i;
  // A full queue still takes a record when the head leaves on the same edge.
  assign push     = eligible && (!is_full || pop);
  assign drop     = eligible && is_full && !pop;
  assign wr_data  = {res_pc_i, res_target_i, res_taken_i, res_mispredict_i, res_cf_i};

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      drop_cnt_reg <= '0;
      misp_cnt_reg <= '0;
    end else if (flush_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
      if (drop && (drop_cnt_reg != 16'hFFFF))
        drop_cnt_reg <= drop_cnt_reg + 16'd1;
      if (push && res_mispredict_i && (misp_cnt_reg != 32'hFFFF_FFFF))
        misp_cnt_reg <= misp_cnt_reg + 32'd1;
    end
  end

  // Storage carries no reset; stale entries are never visible because valid tracks occupancy.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk_i) begin
        if (!rst_i && !flush_i && push && (wr_ptr_reg == AW'(gi)))
          mem_reg[gi] <= wr_data;
      end
    end
  endgenerate

  assign head_data = is_empty ? '0 : mem_reg[rd_ptr_reg];

  assign upd_valid_o      = !is_empty;
  assign upd_pc_o         = head_data[RW-1 -: VLEN];
  assign upd_target_o     = head_data[TGTW+4 : 5];
  assign upd_taken_o      = head_data[4];
  assign upd_mispredict_o = head_data[3];
  assign upd_cf_o         = head_data[2:0];
  assign full_o           = is_full;
  assign drop_cnt_o       = drop_cnt_reg;
  assign mispredict_cnt_o = misp_cnt_reg;

endmodule

// File: tb/tb_bp_update_queue.sv
// Directed scenarios followed by random traffic, all compared against a queue-based model.
module tb_bp_update_queue;

  localparam int DEPTH = 4;
  localparam int VLEN  = 64;
  localparam int TGTW  = 128;

  typedef struct {
    logic [VLEN-1:0] pc;
    logic [TGTW-1:0] tgt;
    logic            taken;
    logic            misp;
    logic [2:0]      cf;
  } rec_t;

  logic            clk = 1'b0;
  logic            rst_i, flush_i, res_valid_i, res_taken_i, res_mispredict_i, upd_ready_i;
  logic [VLEN-1:0] res_pc_i;
  logic [TGTW-1:0] res_target_i;
  logic [2:0]      res_cf_i;
  logic            upd_valid_o, upd_taken_o, upd_mispredict_o, full_o;
  logic [VLEN-1:0] upd_pc_o;
  logic [TGTW-1:0] upd_target_o;
  logic [2:0]      upd_cf_o;
  logic [15:0]     drop_cnt_o;
  logic [31:0]     mispredict_cnt_o;

  bp_update_queue #(.DEPTH(DEPTH), .VLEN(VLEN), .TGTW(TGTW)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .res_valid_i(res_valid_i), .res_pc_i(res_pc_i), .res_target_i(res_target_i),
    .res_taken_i(res_taken_i), .res_mispredict_i(res_mispredict_i), .res_cf_i(res_cf_i),
    .upd_valid_o(upd_valid_o), .upd_ready_i(upd_ready_i),
    .upd_pc_o(upd_pc_o), .upd_target_o(upd_target_o), .upd_taken_o(upd_taken_o),
    .upd_mispredict_o(upd_mispredict_o), .upd_cf_o(upd_cf_o),
    .full_o(full_o), .drop_cnt_o(drop_cnt_o), .mispredict_cnt_o(mispredict_cnt_o)
  );

  always #5 clk = ~clk;

  rec_t q[$];
  int   m_drops, m_misp;
  int   vectors, miscompares;

  task automatic chk(input string tag, input logic [TGTW-1:0] obs, input logic [TGTW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    rec_t h;
    h = '{pc: '0, tgt: '0, taken: 1'b0, misp: 1'b0, cf: 3'd0};
    if (q.size() != 0) h = q[0];
    chk("valid", upd_valid_o, q.size() != 0);
    chk("full", full_o, q.size() == DEPTH);
    chk("pc", upd_pc_o, h.pc);
    chk("target", upd_target_o, h.tgt);
    chk("taken", upd_taken_o, h.taken);
    chk("mispredict", upd_mispredict_o, h.misp);
    chk("cf", upd_cf_o, h.cf);
    chk("drop_cnt", drop_cnt_o, m_drops);
    chk("misp_cnt", mispredict_cnt_o, m_misp);
  endtask

  // Check current state, then advance the model and the DUT by one edge.
  task automatic cycle();
    rec_t r;
    bit   elig, popping, was_full;
    #1;
    check_model();
    r = '{pc: res_pc_i, tgt: res_target_i, taken: res_taken_i, misp: res_mispredict_i, cf: res_cf_i};
    elig     = res_valid_i && (res_cf_i == 3'd1 || res_mispredict_i);
    popping  = (q.size() != 0) && upd_ready_i;
    was_full = (q.size() == DEPTH);
    @(posedge clk);
    #1;
    if (rst_i) begin
      q.delete();
      m_drops = 0;
      m_misp  = 0;
    end else if (flush_i) begin
      q.delete();
    end else begin
      if (popping) void'(q.pop_front());
      if (elig) begin
        if (!was_full || popping) begin
          q.push_back(r);
          if (r.misp && m_misp != 32'hFFFF_FFFF) m_misp++;
        end else if (m_drops != 16'hFFFF) begin
          m_drops++;
        end
      end
    end
  endtask

  task automatic apply(input bit v, input logic [2:0] cf, input bit m, input bit tk,
                       input logic [VLEN-1:0] pc, input bit rdy, input bit fl, input bit rs);
    res_valid_i      = v;
    res_cf_i         = cf;
    res_mispredict_i = m;
    res_taken_i      = tk;
    res_pc_i         = pc;
    res_target_i     = {pc, ~pc};
    upd_ready_i      = rdy;
    flush_i          = fl;
    rst_i            = rs;
    cycle();
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) apply(0, 3'd0, 0, 0, '0, 1, 0, 0);
  endtask

  initial begin
    vectors = 0; miscompares = 0; m_drops = 0; m_misp = 0;
    apply(0, 3'd0, 0, 0, '0, 0, 0, 1);
    apply(1, 3'd1, 1, 1, 64'h55, 1, 0, 1);
    chk("reset_valid", upd_valid_o, 1'b0);
    chk("reset_full", full_o, 1'b0);

    // Single push appears one cycle later, then leaves
    apply(1, 3'd1, 0, 1, 64'h1000, 1, 0, 0);
    chk("single_valid", upd_valid_o, 1'b1);
    chk("single_pc", upd_pc_o, 64'h1000);
    apply(0, 3'd0, 0, 0, '0, 1, 0, 0);
    chk("single_gone", upd_valid_o, 1'b0);

    // Filtering
    apply(1, 3'd2, 0, 1, 64'h1100, 0, 0, 0);
    chk("filter_jump", upd_valid_o, 1'b0);
    apply(1, 3'd3, 1, 1, 64'h1200, 0, 0, 0);
    chk("filter_jumpr_pc", upd_pc_o, 64'h1200);
    chk("filter_misp_cnt", mispredict_cnt_o, 32'd1);
    drain();

    // Fill with overflow, then pop in order
    for (int i = 0; i < 5; i++) begin
      apply(1, 3'd1, 0, 1, 64'h2000 + 64'(i), 0, 0, 0);
      if (i == 3) chk("fill_full", full_o, 1'b1);
    end
    chk("fill_drop", drop_cnt_o, 16'd1);
    for (int i = 0; i < 4; i++) begin
      chk("fill_order", upd_pc_o, 64'h2000 + 64'(i));
      apply(0, 3'd0, 0, 0, '0, 1, 0, 0);
    end

    // Full with simultaneous push and pop
    for (int i = 0; i < 4; i++) apply(1, 3'd1, 0, 0, 64'h3000 + 64'(i), 0, 0, 0);
    apply(1, 3'd1, 0, 0, 64'h3004, 1, 0, 0);
    chk("swap_full", full_o, 1'b1);
    chk("swap_drop", drop_cnt_o, 16'd1);
    chk("swap_head", upd_pc_o, 64'h3001);
    drain();

    // Flush with a coincident push
    for (int i = 0; i < 3; i++) apply(1, 3'd1, 1, 0, 64'h4000 + 64'(i), 0, 0, 0);
    apply(1, 3'd1, 1, 0, 64'h4003, 0, 1, 0);
    chk("flush_valid", upd_valid_o, 1'b0);
    chk("flush_drop", drop_cnt_o, 16'd1);
    chk("flush_misp", mispredict_cnt_o, 32'd4);

    // Reset mid-operation
    for (int i = 0; i < 8; i++) apply(1, 3'd1, 0, 0, 64'h5000 + 64'(i), 0, 0, 0);
    apply(0, 3'd0, 0, 0, '0, 1, 0, 0);
    apply(0, 3'd0, 0, 0, '0, 1, 0, 0);
    chk("pre_reset_drop", drop_cnt_o, 16'd5);
    apply(1, 3'd1, 1, 0, 64'h5100, 1, 0, 1);
    chk("rst_valid", upd_valid_o, 1'b0);
    chk("rst_drop", drop_cnt_o, 16'd0);
    chk("rst_misp", mispredict_cnt_o, 32'd0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      apply($urandom_range(99) < 70, 3'($urandom_range(7)), $urandom_range(99) < 30,
            1'($urandom), {$urandom, $urandom}, $urandom_range(99) < 45,
            $urandom_range(99) < 3, $urandom_range(99) < 1);
    end
    apply(0, 3'd0, 0, 0, '0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bp_update_queue.md
BP_UPDATE_QUEUE -- requirements
Module: bp_update_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of queue entries (power of 2, >=2).
REQ-002 SHALL have parameter VLEN, default 64, meaning width of the virtual PC field.
REQ-003 SHALL have parameter TGTW, default 128, meaning width of the target field (full PCC when CHERI is present, VLEN otherwise).
REQ-004 SHALL have port clk_i, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i, input, 1, meaning synchronous, active-high reset.
REQ-006 SHALL have port flush_i, input, 1, meaning discard all queued records (predictor flush).
REQ-007 SHALL have port res_valid_i, input, 1, meaning a resolved-branch record from the branch unit is present this cycle.
REQ-008 SHALL have port res_pc_i, input, VLEN, meaning PC of the resolved instruction.
REQ-009 SHALL have port res_target_i, input, TGTW, meaning resolved target.
REQ-010 SHALL have port res_taken_i, input, 1, meaning branch taken.
REQ-011 SHALL have port res_mispredict_i, input, 1, meaning resolution disagreed with the prediction.
REQ-012 SHALL have port res_cf_i, input, 3, meaning control-flow type (0 NoCF, 1 Branch, 2 Jump, 3 JumpR, 4 Return).
REQ-013 SHALL have port upd_valid_o, input-side counterpart output, 1, meaning the head record is offered to the predictor.
REQ-014 SHALL have port upd_ready_i, input, 1, meaning the predictor accepts the head record.
REQ-015 SHALL have ports upd_pc_o (VLEN), upd_target_o (TGTW), upd_taken_o (1), upd_mispredict_o (1), upd_cf_o (3), all outputs, meaning the head record fields.
REQ-016 SHALL have port full_o, output, 1, meaning all DEPTH entries are occupied.
REQ-017 SHALL have port drop_cnt_o, output, 16, meaning count of records dropped because the queue was full.
REQ-018 SHALL have port mispredict_cnt_o, output, 32, meaning count of accepted records with the mispredict flag set.

Function
REQ-019 SHALL treat a record as eligible when res_valid_i=1 and (res_cf_i=1 or res_mispredict_i=1); ineligible records are ignored and counted nowhere.
REQ-020 SHALL push an eligible record in the cycle it is presented if not full, or if full and a pop occurs in the same cycle.
REQ-021 SHALL drop an eligible record when full and no pop occurs that cycle, and SHALL increment drop_cnt_o, saturating at 0xFFFF.
REQ-022 SHALL pop the head when upd_valid_o=1 and upd_ready_i=1 (handshake on the same edge).
REQ-023 SHALL assert upd_valid_o exactly when occupancy is nonzero; a pushed record first appears at the outputs one cycle after the push (no combinational bypass).
REQ-024 SHALL keep upd_* outputs stable while upd_valid_o=1 and upd_ready_i=0.
REQ-025 SHALL deliver records in strict FIFO order; read/write pointers wrap modulo DEPTH.
REQ-026 SHALL track occupancy 0..DEPTH; full_o=1 iff occupancy=DEPTH; simultaneous push and pop leave occupancy unchanged.
REQ-027 SHALL increment mispredict_cnt_o on each pushed record with res_mispredict_i=1, saturating at 0xFFFFFFFF; dropped records do not increment it.
REQ-028 SHALL, on flush_i=1, set occupancy and both pointers to 0 at the next edge; a push or pop in the same cycle is discarded; counters are not cleared by flush.
REQ-029 SHALL drive upd_pc_o, upd_target_o, upd_taken_o, upd_mispredict_o, upd_cf_o to 0 when upd_valid_o=0.

Reset
REQ-030 SHALL, while rst_i=1 at a clock edge, set occupancy, pointers, drop_cnt_o and mispredict_cnt_o to 0; upd_valid_o=0, full_o=0 in the following cycle.
REQ-031 SHALL give reset priority over flush_i, push and pop; records presented during reset are discarded and not counted.

Verification
REQ-032 Single push: Branch, pc=0x1000, taken=1, upd_ready_i=1 -> upd_valid_o=1 with upd_pc_o=0x1000 exactly one cycle later, then 0.
REQ-033 Fill: 5 eligible records, upd_ready_i=0, DEPTH=4 -> full_o=1 after 4th, drop_cnt_o=1, pops return first 4 in order.
REQ-034 Full with simultaneous push/pop: queue full, upd_ready_i=1, new record -> accepted, occupancy stays 4, drop_cnt_o unchanged.
REQ-035 Filtering: cf=Jump mispredict=0 -> not queued; cf=JumpR mispredict=1 -> queued, mispredict_cnt_o increments to 1.
REQ-036 Flush with push: occupancy 3, flush_i=1 plus eligible record -> next cycle upd_valid_o=0, counters retained.
REQ-037 Reset mid-operation: occupancy 2, drop_cnt_o=5, rst_i=1 one cycle -> upd_valid_o=0, drop_cnt_o=0, mispredict_cnt_o=0.
